datapath_rr_scheduler: RTL

//  Round-robin scheduler sharing one iterative datapath (and its start/complete sequencing controller) between N requesters.

---
 rtl/datapath_rr_scheduler_pkg.sv | 18 +
 rtl/datapath_rr_scheduler_if.sv | 31 +++
 rtl/datapath_rr_scheduler_rr_picker.sv | 40 ++++
 rtl/datapath_rr_scheduler.sv | 122 ++++++++++++
 4 files changed

// File: rtl/datapath_rr_scheduler_pkg.sv
// Shared FSM encodings and default sizing for the round-robin datapath scheduler.
// Pure definitions: no logic, no latency, no flow control.
package datapath_rr_scheduler_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_ABORT   = 3'd4;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/datapath_rr_scheduler_if.sv
// Requester and datapath-controller signals of the scheduler, bundled as one port.
// master = requesters plus datapath model side; slave = scheduler side.
interface datapath_rr_scheduler_if
    import datapath_rr_scheduler_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        err;
    logic [DATA_W-1:0]       resp_data;
    logic [N_REQ-1:0]        grant;
    logic                    busy;
    logic                    dp_start;
    logic [DATA_W-1:0]       dp_in;
    logic                    dp_done;
    logic [DATA_W-1:0]       dp_result;

    modport master (
        output req, req_data, dp_done, dp_result,
        input  ack, err, resp_data, grant, busy, dp_start, dp_in
    );

    modport slave (
        input  req, req_data, dp_done, dp_result,
        output ack, err, resp_data, grant, busy, dp_start, dp_in
    );

endinterface

// File: rtl/datapath_rr_scheduler_rr_picker.sv
// Combinational round-robin pick: first set req bit scanning from ptr upward, with wrap.
// Zero latency; no flow control (pure function of req and ptr).
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant_next,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);
    localparam int PW = IDX_W + 1;

    // Scan from the farthest offset down so the closest set bit to ptr is written last.
    always_comb begin : scan
        logic [PW-1:0] w_pos;
        w_pos = '0;
        o_any = 1'b0;
        o_idx = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            w_pos = {1'b0, i_ptr} + PW'(off);
            if (w_pos >= PW'(N_REQ)) begin
                w_pos = w_pos - PW'(N_REQ);
            end
            if (i_req[w_pos[IDX_W-1:0]]) begin
                o_any = 1'b1;
                o_idx = w_pos[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        o_grant_next = '0;
        for (int i = 0; i < N_REQ; i++) begin
            o_grant_next[i] = o_any && (o_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/datapath_rr_scheduler.sv
// Shares one iterative datapath among N_REQ requesters in round-robin order; ack/err one cycle after done/timeout.
// No backpressure: requesters hold req until ack or err, the datapath is expected to raise dp_done.
module datapath_rr_scheduler
    import datapath_rr_scheduler_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    datapath_rr_scheduler_if.slave io
);
    localparam int IDX_W = $clog2(N_REQ);

    state_t              r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [N_REQ-1:0]    r_grant;
    logic [N_REQ-1:0]    r_ack;
    logic [N_REQ-1:0]    r_err;
    logic                r_busy;
    logic                r_dp_start;
    logic [DATA_W-1:0]   r_dp_in;
    logic [DATA_W-1:0]   r_resp_data;

    logic [N_REQ-1:0]    w_grant_next;
    logic [IDX_W-1:0]    w_idx;
    logic                w_any;
    logic [DATA_W-1:0]   w_sel_data;
    logic [IDX_W-1:0]    w_ptr_next;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req        (io.req),
        .i_ptr        (r_ptr),
        .o_grant_next (w_grant_next),
        .o_idx        (w_idx),
        .o_any        (w_any)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_sel_data = io.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_ptr_next = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

    // ack/err reuse the owner's one-hot grant, so at most one bit can ever pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_grant     <= '0;
            r_ack       <= '0;
            r_err       <= '0;
            r_busy      <= 1'b0;
            r_dp_start  <= 1'b0;
            r_dp_in     <= '0;
            r_resp_data <= '0;
        end else begin
            r_dp_start <= 1'b0;
            r_ack      <= '0;
            r_err      <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant    <= w_grant_next;
                        r_dp_in    <= w_sel_data;
                        r_ptr      <= w_ptr_next;
                        r_dp_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (io.dp_done) begin
                        r_resp_data <= io.dp_result;
                        r_ack       <= r_grant;
                        r_state     <= ST_RELEASE;
                    end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                        r_err   <= r_grant;
                        r_state <= ST_ABORT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RELEASE, ST_ABORT: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io.ack       = r_ack;
    assign io.err       = r_err;
    assign io.grant     = r_grant;
    assign io.busy      = r_busy;
    assign io.dp_start  = r_dp_start;
    assign io.dp_in     = r_dp_in;
    assign io.resp_data = r_resp_data;

endmodule
